// File: rtl/selector.sv
// Operation selector encodings shared by the decode stage and the mul/div unit.
// Latency: none (type definitions only).
// Backpressure: not applicable.
package selector;

  typedef enum logic [2:0] {
    MULDIV_MULT  = 3'd0,
    MULDIV_MULTU = 3'd1,
    MULDIV_DIV   = 3'd2,
    MULDIV_DIVU  = 3'd3,
    MULDIV_NCARE = 3'd7
  } muldiv_funct_t;

endpackage

// File: rtl/signals.sv
// Shared control-signal types for the execute-stage units.
// Latency: none (type definitions only).
// Backpressure: not applicable.
package signals;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-divide iteration: shift in the next dividend bit, trial-subtract the divisor.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module div_step (
  input  logic [32:0] rem_in,
  input  logic        dividend_bit,
  input  logic [31:0] divisor,
  output logic [32:0] rem_out,
  output logic        q_bit
);

  logic [33:0] shifted;
  logic [33:0] diff;

  // Trial subtraction; a borrow (top bit set) means restore the shifted remainder.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[33];
    rem_out = q_bit ? diff[32:0] : shifted[32:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit (MULT/MULTU/DIV/DIVU) producing {hi,lo}; optional MULDIV_FAST_MULT_EN.
// Latency: done 34 cycles after the start cycle (2 for multiply when MULDIV_FAST_MULT_EN is defined).
// Backpressure: start ignored while busy; flush aborts an operation and suppresses its done pulse.
module muldiv_unit
  import selector::*;
  import signals::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  muldiv_funct_t funct,
  input  logic [31:0]   a,
  input  logic [31:0]   b,
  input  logic          flush,
  output logic          busy,
  output logic          done,
  output logic [31:0]   hi,
  output logic [31:0]   lo
);

  muldiv_state_t state;
  logic [4:0]    cnt;
  logic [32:0]   acc_hi;    // product high word (multiply) or partial remainder (divide)
  logic [31:0]   acc_lo;    // multiplier shifting out / dividend shifting out, quotient shifting in
  logic [31:0]   opnd;      // multiplicand magnitude or divisor magnitude
  logic [31:0]   a_reg;     // raw dividend, returned as the remainder on divide-by-zero
  logic          is_mul;
  logic          neg_main;  // negate product or quotient in FIX
  logic          neg_rem;   // negate remainder in FIX
  logic          div_zero;

  logic          accept;
  logic          sgn_op;
  logic          mul_op;
  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic [32:0]   mul_sum;
  logic [32:0]   rem_nxt;
  logic          q_bit;
  logic [63:0]   raw_prod;
  logic [63:0]   fix_prod;
  logic [31:0]   fix_quo;
  logic [31:0]   fix_rem;

  assign busy = (state != IDLE);

  div_step u_div_step (
    .rem_in       (acc_hi),
    .dividend_bit (acc_lo[31]),
    .divisor      (opnd),
    .rem_out      (rem_nxt),
    .q_bit        (q_bit)
  );

  // Operand decode, shift-add step and sign fix-up of the finished magnitudes.
  always_comb begin
    accept  = start & ~busy & ~flush & (funct != MULDIV_NCARE);
    sgn_op  = (funct == MULDIV_MULT) | (funct == MULDIV_DIV);
    mul_op  = (funct == MULDIV_MULT) | (funct == MULDIV_MULTU);
    mag_a   = (sgn_op & a[31]) ? (32'd0 - a) : a;
    mag_b   = (sgn_op & b[31]) ? (32'd0 - b) : b;
    mul_sum = {1'b0, acc_hi[31:0]} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
`ifdef MULDIV_FAST_MULT_EN
    raw_prod = {32'd0, opnd} * {32'd0, acc_lo};
`else
    raw_prod = {acc_hi[31:0], acc_lo};
`endif
    fix_prod = neg_main ? (64'd0 - raw_prod) : raw_prod;
    fix_quo  = neg_main ? (32'd0 - acc_lo) : acc_lo;
    fix_rem  = neg_rem ? (32'd0 - acc_hi[31:0]) : acc_hi[31:0];
  end

  // Control FSM and datapath registers; flush or reset abandons the operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      acc_hi   <= 33'd0;
      acc_lo   <= 32'd0;
      opnd     <= 32'd0;
      a_reg    <= 32'd0;
      is_mul   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= 5'd0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              cnt      <= 5'd0;
              acc_hi   <= 33'd0;
              opnd     <= mul_op ? mag_a : mag_b;
              acc_lo   <= mul_op ? mag_b : mag_a;
              a_reg    <= a;
              is_mul   <= mul_op;
              neg_main <= sgn_op & (a[31] ^ b[31]);
              neg_rem  <= sgn_op & a[31];
              div_zero <= (b == 32'd0);
`ifdef MULDIV_FAST_MULT_EN
              state    <= mul_op ? FIX : DIV;
`else
              state    <= mul_op ? MUL : DIV;
`endif
            end
          end
          MUL: begin
            acc_hi <= {1'b0, mul_sum[32:1]};
            acc_lo <= {mul_sum[0], acc_lo[31:1]};
            cnt    <= cnt + 5'd1;
            if (cnt == 5'd31) state <= FIX;
          end
          DIV: begin
            acc_hi <= rem_nxt;
            acc_lo <= {acc_lo[30:0], q_bit};
            cnt    <= cnt + 5'd1;
            if (cnt == 5'd31) state <= FIX;
          end
          FIX: begin
            done  <= 1'b1;
            state <= IDLE;
            if (is_mul) begin
              hi <= fix_prod[63:32];
              lo <= fix_prod[31:0];
            end else if (div_zero) begin
              hi <= a_reg;
              lo <= 32'hFFFF_FFFF;
            end else begin
              hi <= fix_rem;
              lo <= fix_quo;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; all datapaths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new operation this cycle.
REQ-005 funct  input  selector::muldiv_funct_t  operation: MULDIV_MULT, MULDIV_MULTU, MULDIV_DIV, MULDIV_DIVU or MULDIV_NCARE.
REQ-006 a  input  32  operand from $rs (dividend or multiplicand).
REQ-007 b  input  32  operand from $rt (divisor or multiplier).
REQ-008 flush  input  1  pipeline cancel; aborts any operation in progress.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse; hi and lo are valid in that cycle.
REQ-011 hi  output  32  result high word (product[63:32] or remainder).
REQ-012 lo  output  32  result low word (product[31:0] or quotient).

Function
REQ-013 FSM states: IDLE, MUL, DIV, FIX. Transitions: IDLE->MUL/DIV on an accepted start; MUL/DIV->FIX after 32 iterations; FIX->IDLE, with done=1 in the cycle after FIX.
REQ-014 A start is accepted only when busy=0, flush=0 and funct!=MULDIV_NCARE; any other start is ignored with no state change.
REQ-015 a, b and funct are captured on the accepting edge; later changes to the inputs do not affect the result.
REQ-016 Signed ops (MULT, DIV) work on magnitudes; the FIX state applies the signs:
  - product sign = a[31]^b[31];
  - quotient sign = a[31]^b[31];
  - remainder sign = a[31].
REQ-017 Multiply is radix-2 shift-add, one bit per cycle; the result is the full 64-bit product {hi,lo}.
REQ-018 Divide is radix-2 restoring, one quotient bit per cycle, using a 33-bit partial remainder.
REQ-019 Latency: done=1 exactly 34 cycles after the accepting edge (32 iterations + FIX + output register); busy=1 in each of the 33 cycles before done.
REQ-020 busy=0 in the done cycle, so a start in that cycle is accepted (back-to-back operation).
REQ-021 Divide by zero: lo=32'hFFFF_FFFF and hi=a for both DIV and DIVU, with normal latency.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
REQ-023 flush while busy: go to IDLE on the next edge, suppress done, leave hi/lo unchanged. flush with start in the same cycle: flush wins.
REQ-024 hi/lo hold their last completed result until the next done pulse.

Reset
REQ-025 While reset=1: state=IDLE, busy=0, done=0, hi=0, lo=0, and all internal registers are cleared.
REQ-026 Reset asserted mid-operation discards the operation; no done follows deassertion.

Configuration
REQ-027 Macro MULDIV_FAST_MULT_EN, when defined:
  - MULT/MULTU compute a single-cycle 64-bit product, registered in FIX;
  - done=1 exactly 2 cycles after the accepting edge;
  - busy=1 for 1 cycle.
REQ-028 When MULDIV_FAST_MULT_EN is undefined, multiply uses the iterative path of REQ-017 with 34-cycle latency. Divide behaviour is identical in both configurations.

Structure
REQ-029 muldiv_state_t (IDLE/MUL/DIV/FIX) is defined in the shared signals package. muldiv_funct_t and its MULDIV_* values stay in the selector package.
REQ-030 One combinational sub-module, div_step, performs one restoring-divide iteration (33-bit remainder in, shifted remainder and quotient bit out).
REQ-031 The iteration counter is 5 bits wide and wraps from 31 to 0 on the transition into FIX.

Verification
REQ-032 MULT a=0xFFFFFFFE, b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; done at cycle 34 (cycle 2 with MULDIV_FAST_MULT_EN).
REQ-033 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064, done at cycle 34.
REQ-036 DIVU 100/7 started, flush at cycle 10 -> busy=0 at cycle 11, no done, hi/lo keep prior values. Repeat with reset at cycle 10 -> same outputs, with hi=lo=0.
REQ-037 start held across done with a new MULTU 5*6 -> accepted in the done cycle, second done 34 cycles later with hi=0, lo=30. A start with funct=MULDIV_NCARE is ignored.
